// File: rtl/carpark_pkg.sv
// Shared definitions for the car-park occupancy block.
//   CNT_W          width of the binary occupancy count
//   SEG_*          active-low seven-segment glyphs, bit order {g,f,e,d,c,b,a}
//   event_t        decoded {exit, enter} pulse pair
//   seg_glyph      BCD digit -> glyph
//   bcd_inc/dec    3-digit BCD increment/decrement with per-digit carry/borrow
package carpark_pkg;

    localparam int CNT_W = 10;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Encoding is {exit, enter} so the raw pulses can be cast directly.
    typedef enum logic [1:0] {
        EV_NONE = 2'b00,
        EV_IN   = 2'b01,
        EV_OUT  = 2'b10,
        EV_BOTH = 2'b11
    } event_t;

    function automatic logic [6:0] seg_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        {h, t, o} = v;
        if (o == 4'd9) begin
            o = 4'd0;
            if (t == 4'd9) begin
                t = 4'd0;
                h = h + 4'd1;
            end else begin
                t = t + 4'd1;
            end
        end else begin
            o = o + 4'd1;
        end
        return {h, t, o};
    endfunction

    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        {h, t, o} = v;
        if (o == 4'd0) begin
            o = 4'd9;
            if (t == 4'd0) begin
                t = 4'd9;
                h = h - 4'd1;
            end else begin
                t = t - 4'd1;
            end
        end else begin
            o = o - 4'd1;
        end
        return {h, t, o};
    endfunction

endpackage

// File: rtl/carpark_occupancy_seg_scan.sv
// Multiplexed 4-digit seven-segment driver for the occupancy display.
//   clk, reset   clock, async active-high reset
//   count_bcd    {hundreds, tens, ones}
//   full, err    status shown in the leftmost digit (E beats F)
//   seg          active-low segments {g,f,e,d,c,b,a}
//   an           active-low digit enables, an[0] = rightmost digit
module seg_scan
    import carpark_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] count_bcd,
    input  logic        full,
    input  logic        err,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int PS_W = $clog2(SCAN_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(SCAN_DIV - 1);

    logic [PS_W-1:0] presc;
    logic [1:0]      idx;
    logic [1:0]      idx_nxt;
    logic [6:0]      seg_nxt;
    logic [3:0]      an_nxt;
    logic [3:0]      dig_h;
    logic [3:0]      dig_t;
    logic [3:0]      dig_o;

    assign {dig_h, dig_t, dig_o} = count_bcd;

    // seg and an are both decoded from the next index so they switch on the
    // same edge; no cycle shows one digit's segments on another's anode.
    always_comb begin
        idx_nxt = (presc == PS_LAST) ? idx + 2'd1 : idx;
        seg_nxt = SEG_BLANK;
        case (idx_nxt)
            2'd0: seg_nxt = seg_glyph(dig_o);
            2'd1: seg_nxt = (dig_h == 4'd0 && dig_t == 4'd0) ? SEG_BLANK : seg_glyph(dig_t);
            2'd2: seg_nxt = (dig_h == 4'd0) ? SEG_BLANK : seg_glyph(dig_h);
            2'd3: seg_nxt = err ? SEG_E : (full ? SEG_F : SEG_BLANK);
            default: seg_nxt = SEG_BLANK;
        endcase
        an_nxt = ~(4'b0001 << idx_nxt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= 2'd0;
            seg   <= SEG_0;
            an    <= 4'b1110;
        end else begin
            presc <= (presc == PS_LAST) ? '0 : presc + 1'b1;
            idx   <= idx_nxt;
            seg   <= seg_nxt;
            an    <= an_nxt;
        end
    end

endmodule

// File: rtl/carpark_occupancy.sv
// Car-park occupancy tracker fed by the gate FSM's one-cycle enter/exit pulses.
//   clk, reset          clock, async active-high reset
//   enter, exit         one-cycle pulses per completed car movement
//   clr_err             synchronous clear of the sticky error flags
//   count, count_bcd    occupancy in binary and BCD {h,t,o}
//   free, full, empty   derived occupancy status
//   err_over, err_under sticky illegal-event flags
//   seg, an             multiplexed seven-segment display
module carpark_occupancy
    import carpark_pkg::*;
#(
    parameter int CAPACITY = 99,
    parameter int SCAN_DIV = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter,
    input  logic             exit,
    input  logic             clr_err,
    output logic [CNT_W-1:0] count,
    output logic [11:0]      count_bcd,
    output logic [CNT_W-1:0] free,
    output logic             full,
    output logic             empty,
    output logic             err_over,
    output logic             err_under,
    output logic [6:0]       seg,
    output logic [3:0]       an
);

    localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);

    event_t           ev;
    logic [CNT_W-1:0] count_nxt;
    logic [11:0]      bcd_nxt;
    logic             set_over;
    logic             set_under;

    assign ev = event_t'({exit, enter});

    // full/empty are registered alongside count, so they describe the
    // current count and can gate the decode directly.
    always_comb begin
        count_nxt = count;
        bcd_nxt   = count_bcd;
        set_over  = 1'b0;
        set_under = 1'b0;
        case (ev)
            EV_IN: begin
                if (full) begin
                    set_over = 1'b1;
                end else begin
                    count_nxt = count + 1'b1;
                    bcd_nxt   = bcd_inc(count_bcd);
                end
            end
            EV_OUT: begin
                if (empty) begin
                    set_under = 1'b1;
                end else begin
                    count_nxt = count - 1'b1;
                    bcd_nxt   = bcd_dec(count_bcd);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            count_bcd <= '0;
            free      <= CAP_V;
            full      <= 1'b0;
            empty     <= 1'b1;
            err_over  <= 1'b0;
            err_under <= 1'b0;
        end else begin
            count     <= count_nxt;
            count_bcd <= bcd_nxt;
            free      <= CAP_V - count_nxt;
            full      <= (count_nxt == CAP_V);
            empty     <= (count_nxt == '0);
            // A new error in the clearing cycle must not be lost.
            err_over  <= set_over  | (err_over  & ~clr_err);
            err_under <= set_under | (err_under & ~clr_err);
        end
    end

    seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .clk       (clk),
        .reset     (reset),
        .count_bcd (count_bcd),
        .full      (full),
        .err       (err_over | err_under),
        .seg       (seg),
        .an        (an)
    );

endmodule
